// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    ParNone = 2'd0,
    ParOdd  = 2'd1,
    ParEven = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreakWait
  } rx_state_t;

  localparam int unsigned MaxDataBits = 9;

  // Expected parity bit for a word; narrower words are zero-extended, which leaves the XOR intact.
  function automatic logic calc_parity(input logic [MaxDataBits-1:0] data, input parity_t mode);
    logic p;
    unique case (mode)
      ParOdd:  p = ~^data;
      ParEven: p = ^data;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit cycle counter and 3-sample majority vote around mid-bit.
module uart_rx_sampler #(
  parameter int unsigned ClksPerBit = 16,
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  input  logic busy_i,
  input  logic cnt_en_i,
  output logic s_o,
  output logic sample_valid_o,
  output logic bit_value_o,
  output logic bit_end_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam int unsigned Half = ClksPerBit / 2;
  localparam logic [CntW-1:0] CntLast   = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntEarly  = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntMid    = CntW'(Half);
  localparam logic [CntW-1:0] CntDecide = CntW'(Half + 1);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  early_q, early_d;
  logic                  mid_q, mid_d;
  logic                  s;

  assign s   = sync_q[SyncStages-1];
  assign s_o = s;

  always_comb begin
    sync_d  = {sync_q[SyncStages-2:0], in_i};
    cnt_d   = cnt_q;
    early_d = early_q;
    mid_d   = mid_q;
    if (!cnt_en_i) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_q == CntEarly) early_d = s;
    if (cnt_q == CntMid)   mid_d   = s;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      early_q <= 1'b1;
      mid_q   <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      early_q <= early_d;
      mid_q   <= mid_d;
    end
  end

  assign sample_valid_o = busy_i && (cnt_q == CntDecide);
  assign bit_end_o      = busy_i && (cnt_q == CntLast);
  assign bit_value_o    = (early_q & mid_q) | (early_q & s) | (mid_q & s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: framing FSM plus valid/ready holding register with error flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 250000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun
);

  localparam int unsigned ClksPerBit  = CLK_FREQ / BAUD;
  localparam parity_t     ParMode     = parity_t'(PARITY[1:0]);
  localparam logic [3:0]  LastDataBit = 4'(DATA_BITS - 1);
  localparam logic        LastStopBit = 1'(STOP_BITS - 1);

  if (ClksPerBit < 4) begin : g_bad_baud
    $error("CLK_FREQ/BAUD must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY > 2) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  rx_state_t            state_q, state_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_q, ferr_d;
  logic                 first_stop_q, first_stop_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;

  logic s, sample_valid, bit_value, bit_end;
  logic busy, cnt_en;
  logic frame_done, done_perr, done_ferr, done_brk;
  logic first_stop, frame_err_now;

  assign busy   = state_q inside {StStart, StData, StParity, StStop};
  assign cnt_en = state_d inside {StStart, StData, StParity, StStop};

  uart_rx_sampler #(
    .ClksPerBit(ClksPerBit),
    .SyncStages(SYNC_STAGES)
  ) u_sampler (
    .clk_i         (i_clk),
    .rst_i         (i_rst),
    .in_i          (i_in),
    .busy_i        (busy),
    .cnt_en_i      (cnt_en),
    .s_o           (s),
    .sample_valid_o(sample_valid),
    .bit_value_o   (bit_value),
    .bit_end_o     (bit_end)
  );

  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    stop_idx_d    = stop_idx_q;
    shift_d       = shift_q;
    par_bit_d     = par_bit_q;
    ferr_d        = ferr_q;
    first_stop_d  = first_stop_q;
    frame_done    = 1'b0;
    done_perr     = 1'b0;
    done_ferr     = 1'b0;
    done_brk      = 1'b0;
    first_stop    = (stop_idx_q == 1'b0) ? bit_value : first_stop_q;
    frame_err_now = ferr_q | ~bit_value;

    unique case (state_q)
      StIdle: begin
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        ferr_d     = 1'b0;
        par_bit_d  = 1'b0;
        if (!s) state_d = StStart;
      end
      StStart: begin
        if (sample_valid && bit_value) begin
          state_d = StIdle;
        end else if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (sample_valid) shift_d = {bit_value, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_idx_q == LastDataBit) begin
            state_d = (ParMode != ParNone) ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (sample_valid) par_bit_d = bit_value;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (sample_valid) begin
          if (stop_idx_q == LastStopBit) begin
            // Complete at the decision, not the bit end, so a back-to-back start edge is caught.
            frame_done = 1'b1;
            done_ferr  = frame_err_now;
            done_perr  = (ParMode != ParNone) &&
                         (par_bit_q != calc_parity(MaxDataBits'(shift_q), ParMode));
            done_brk   = (shift_q == '0) && ((ParMode == ParNone) || !par_bit_q) && !first_stop;
            state_d    = done_brk ? StBreakWait : StIdle;
          end else begin
            ferr_d       = frame_err_now;
            first_stop_d = bit_value;
          end
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      StBreakWait: begin
        if (s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_out_d = ferr_out_q;
    brk_d      = brk_q;
    ovr_d      = ovr_q;
    if (frame_done) begin
      if (!valid_q || i_ready) begin
        data_d     = shift_q;
        valid_d    = 1'b1;
        perr_d     = done_perr;
        ferr_out_d = done_ferr;
        brk_d      = done_brk;
        ovr_d      = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d    = 1'b0;
      perr_d     = 1'b0;
      ferr_out_d = 1'b0;
      brk_d      = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      ferr_q       <= 1'b0;
      first_stop_q <= 1'b1;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_out_q   <= 1'b0;
      brk_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      ferr_q       <= ferr_d;
      first_stop_q <= first_stop_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      ferr_out_q   <= ferr_out_d;
      brk_q        <= brk_d;
      ovr_q        <= ovr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_out_q;
  assign o_break      = brk_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations driven by serial frames, checked against a frame model.
module tb_uart_rx_param;

  localparam int unsigned CF   = 16000000;
  localparam int unsigned BD   = 1000000;
  localparam int unsigned CPB  = CF / BD;
  localparam int unsigned SYNC = 2;

  typedef struct {
    int          k;
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
    logic        brk;
    logic        ovr;
    int unsigned cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  line;
  logic [2:0]  ready;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  rec_t        q[$];

  logic [7:0] d0_data, d1_data;
  logic [6:0] d2_data;
  logic d0_valid, d0_perr, d0_ferr, d0_brk, d0_ovr;
  logic d1_valid, d1_perr, d1_ferr, d1_brk, d1_ovr;
  logic d2_valid, d2_perr, d2_ferr, d2_brk, d2_ovr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLK_FREQ(CF), .BAUD(BD)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_in(line[0]), .o_data(d0_data), .o_valid(d0_valid),
    .i_ready(ready[0]), .o_parity_err(d0_perr), .o_frame_err(d0_ferr), .o_break(d0_brk),
    .o_overrun(d0_ovr)
  );

  uart_rx_param #(.CLK_FREQ(CF), .BAUD(BD), .PARITY(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_in(line[1]), .o_data(d1_data), .o_valid(d1_valid),
    .i_ready(ready[1]), .o_parity_err(d1_perr), .o_frame_err(d1_ferr), .o_break(d1_brk),
    .o_overrun(d1_ovr)
  );

  uart_rx_param #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(7), .STOP_BITS(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_in(line[2]), .o_data(d2_data), .o_valid(d2_valid),
    .i_ready(ready[2]), .o_parity_err(d2_perr), .o_frame_err(d2_ferr), .o_break(d2_brk),
    .o_overrun(d2_ovr)
  );

  // Log every accepted transfer, just after the negedge where inputs settle.
  always begin
    @(negedge clk);
    #1;
    if (d0_valid === 1'b1 && ready[0] === 1'b1)
      q.push_back('{0, {1'b0, d0_data}, d0_perr, d0_ferr, d0_brk, d0_ovr, cyc});
    if (d1_valid === 1'b1 && ready[1] === 1'b1)
      q.push_back('{1, {1'b0, d1_data}, d1_perr, d1_ferr, d1_brk, d1_ovr, cyc});
    if (d2_valid === 1'b1 && ready[2] === 1'b1)
      q.push_back('{2, {2'b0, d2_data}, d2_perr, d2_ferr, d2_brk, d2_ovr, cyc});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input int k, input logic v);
    line[k] = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int k, input int n);
    repeat (n) drive_bit(k, 1'b1);
  endtask

  task automatic send_frame(input int k, input logic [8:0] d, input int nd, input int pmode,
                            input logic pbit, input int nstop, input logic [1:0] stops,
                            output int unsigned t0);
    t0 = cyc;
    drive_bit(k, 1'b0);
    for (int i = 0; i < nd; i++) drive_bit(k, d[i]);
    if (pmode != 0) drive_bit(k, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(k, stops[i]);
  endtask

  task automatic wait_rec(output bit got, output rec_t r, input int budget);
    for (int i = 0; i < budget && q.size() == 0; i++) begin
      @(negedge clk);
      #2;
    end
    got = (q.size() != 0);
    if (got) r = q.pop_front();
  endtask

  // Expected delivery from the frame as put on the line.
  function automatic rec_t model_frame(input int k, input logic [8:0] d, input int pmode,
                                       input logic pbit, input int nstop, input logic [1:0] stops);
    rec_t m;
    int   ones;
    ones   = $countones(d) + int'(pbit);
    m.k    = k;
    m.data = d;
    m.perr = (pmode == 2) ? (ones % 2 != 0) : (pmode == 1) ? (ones % 2 == 0) : 1'b0;
    m.ferr = 1'b0;
    for (int i = 0; i < nstop; i++) if (stops[i] == 1'b0) m.ferr = 1'b1;
    m.brk  = (d == 9'd0) && (pmode == 0 || pbit == 1'b0) && (stops[0] == 1'b0);
    m.ovr  = 1'b0;
    m.cyc  = 0;
    return m;
  endfunction

  function automatic int unsigned frame_latency(input int nd, input int pmode, input int nstop);
    int nbits;
    nbits = 1 + nd + ((pmode != 0) ? 1 : 0) + nstop;
    return SYNC + CPB * (nbits - 1) + (CPB / 2 + 1) + 1;
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    line  = 3'b111;
    ready = 3'b111;
    repeat (3) @(negedge clk);
    total++;
    if (d0_valid !== 1'b0 || d1_valid !== 1'b0 || d2_valid !== 1'b0) begin
      $display("FAIL reset_valid: got %b%b%b want 000", d0_valid, d1_valid, d2_valid);
      bad++;
    end
    total++;
    if (d0_data !== 8'h00 || d2_data !== 7'h00) begin
      $display("FAIL reset_data: got %h/%h want 00/00", d0_data, d2_data);
      bad++;
    end
    total++;
    if ({d0_perr, d0_ferr, d0_brk, d0_ovr} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b want 0000", {d0_perr, d0_ferr, d0_brk, d0_ovr});
      bad++;
    end
    rst = 1'b0;
    idle_bits(0, 2);
  endtask

  task automatic test_basic();
    int unsigned t0;
    bit          got;
    rec_t        r;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, t0);
    idle_bits(0, 2);
    wait_rec(got, r, 200);
    total++;
    if (!got) begin
      $display("FAIL basic_valid: got no word want 0xa5");
      bad++;
    end else begin
      if (r.data !== 9'h0A5 || {r.perr, r.ferr, r.brk, r.ovr} !== 4'b0000) begin
        $display("FAIL basic_word: got %h flags %b want a5 flags 0000", r.data,
                 {r.perr, r.ferr, r.brk, r.ovr});
        bad++;
      end
      total++;
      if (r.cyc != t0 + frame_latency(8, 0, 1)) begin
        $display("FAIL basic_latency: got %0d want %0d", r.cyc - t0, frame_latency(8, 0, 1));
        bad++;
      end
    end
    total++;
    if (q.size() != 0) begin
      $display("FAIL basic_single: got %0d extra words want 0", q.size());
      bad++;
    end
  endtask

  task automatic test_parity();
    int unsigned t0;
    bit          got;
    rec_t        r;
    logic [1:0]  exp;
    exp = 2'b10;
    for (int i = 0; i < 2; i++) begin
      send_frame(1, 9'h007, 8, 2, (i == 0), 1, 2'b11, t0);
      idle_bits(1, 2);
      wait_rec(got, r, 200);
      total++;
      if (!got || r.data !== 9'h007 || r.perr !== exp[i]) begin
        $display("FAIL parity_%0d: got valid=%0d data=%h perr=%b want data=07 perr=%b", i, got,
                 r.data, r.perr, exp[i]);
        bad++;
      end
    end
  endtask

  task automatic test_false_start();
    int unsigned t0;
    bit          got;
    rec_t        r;
    line[0] = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(0, 3);
    total++;
    if (q.size() != 0) begin
      $display("FAIL false_start: got %0d words want 0", q.size());
      bad++;
      q.delete();
    end
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 2'b11, t0);
    idle_bits(0, 2);
    wait_rec(got, r, 200);
    total++;
    if (!got || r.data !== 9'h03C || r.ferr !== 1'b0) begin
      $display("FAIL after_false_start: got valid=%0d data=%h ferr=%b want data=3c ferr=0", got,
               r.data, r.ferr);
      bad++;
    end
  endtask

  task automatic test_break();
    int unsigned t0;
    bit          got;
    rec_t        r;
    send_frame(0, 9'h055, 8, 0, 1'b0, 1, 2'b00, t0);
    idle_bits(0, 2);
    wait_rec(got, r, 200);
    total++;
    if (!got || r.data !== 9'h055 || r.ferr !== 1'b1 || r.brk !== 1'b0) begin
      $display("FAIL frame_err: got valid=%0d data=%h ferr=%b brk=%b want 55 1 0", got, r.data,
               r.ferr, r.brk);
      bad++;
    end
    repeat (20) drive_bit(0, 1'b0);
    total++;
    if (q.size() != 1) begin
      $display("FAIL break_count_low: got %0d words want 1", q.size());
      bad++;
    end
    idle_bits(0, 2);
    wait_rec(got, r, 200);
    total++;
    if (!got || r.data !== 9'h000 || r.brk !== 1'b1 || r.ferr !== 1'b1) begin
      $display("FAIL break_word: got valid=%0d data=%h brk=%b ferr=%b want 00 1 1", got, r.data,
               r.brk, r.ferr);
      bad++;
    end
    total++;
    if (q.size() != 0) begin
      $display("FAIL break_single: got %0d extra words want 0", q.size());
      bad++;
      q.delete();
    end
    send_frame(0, 9'h081, 8, 0, 1'b0, 1, 2'b11, t0);
    idle_bits(0, 2);
    wait_rec(got, r, 200);
    total++;
    if (!got || r.data !== 9'h081 || r.brk !== 1'b0 || r.ferr !== 1'b0) begin
      $display("FAIL after_break: got valid=%0d data=%h brk=%b ferr=%b want 81 0 0", got, r.data,
               r.brk, r.ferr);
      bad++;
    end
  endtask

  task automatic test_overrun();
    int unsigned t0;
    bit          got;
    rec_t        r;
    ready[0] = 1'b0;
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11, t0);
    idle_bits(0, 2);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 2'b11, t0);
    idle_bits(0, 2);
    total++;
    if (d0_valid !== 1'b1 || d0_data !== 8'h11 || d0_ovr !== 1'b1) begin
      $display("FAIL overrun_hold: got valid=%b data=%h ovr=%b want 1 11 1", d0_valid, d0_data,
               d0_ovr);
      bad++;
    end
    ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (d0_valid !== 1'b0 || d0_ovr !== 1'b0) begin
      $display("FAIL overrun_clear: got valid=%b ovr=%b want 0 0", d0_valid, d0_ovr);
      bad++;
    end
    wait_rec(got, r, 20);
    total++;
    if (!got || r.data !== 9'h011 || r.ovr !== 1'b1 || q.size() != 0) begin
      $display("FAIL overrun_xfer: got valid=%0d data=%h ovr=%b left=%0d want 11 1 0", got,
               r.data, r.ovr, q.size());
      bad++;
      q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int unsigned t0;
    bit          got;
    rec_t        r;
    ready[0] = 1'b0;
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11, t0);
    idle_bits(0, 2);
    fork
      send_frame(0, 9'h0FF, 8, 0, 1'b0, 1, 2'b11, t0);
      begin
        // Data bit 3 is line bit 4; land the reset in its middle.
        repeat (SYNC + CPB * 4 + 8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if (d0_valid !== 1'b0 || d0_data !== 8'h00 ||
            {d0_perr, d0_ferr, d0_brk, d0_ovr} !== 4'b0000) begin
          $display("FAIL reset_mid_outputs: got valid=%b data=%h flags=%b want 0 00 0000",
                   d0_valid, d0_data, {d0_perr, d0_ferr, d0_brk, d0_ovr});
          bad++;
        end
      end
    join
    ready[0] = 1'b1;
    idle_bits(0, 2);
    total++;
    if (q.size() != 0) begin
      $display("FAIL reset_mid_novalid: got %0d words want 0", q.size());
      bad++;
      q.delete();
    end
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 2'b11, t0);
    idle_bits(0, 2);
    wait_rec(got, r, 200);
    total++;
    if (!got || r.data !== 9'h03C) begin
      $display("FAIL reset_mid_next: got valid=%0d data=%h want 3c", got, r.data);
      bad++;
    end
    send_frame(2, 9'h07F, 7, 0, 1'b0, 2, 2'b11, t0);
    idle_bits(2, 2);
    wait_rec(got, r, 200);
    total++;
    if (!got || r.k != 2 || r.data !== 9'h07F || r.ferr !== 1'b0) begin
      $display("FAIL seven_two_stop: got valid=%0d dut=%0d data=%h ferr=%b want 2 7f 0", got,
               r.k, r.data, r.ferr);
      bad++;
    end else begin
      total++;
      if (r.cyc != t0 + frame_latency(7, 0, 2)) begin
        $display("FAIL seven_two_latency: got %0d want %0d", r.cyc - t0,
                 frame_latency(7, 0, 2));
        bad++;
      end
    end
  endtask

  task automatic test_random();
    int          nd[3]    = '{8, 8, 7};
    int          pm[3]    = '{0, 2, 0};
    int          ns[3]    = '{1, 1, 2};
    int unsigned t0;
    bit          got;
    rec_t        r;
    rec_t        m;
    logic [8:0]  d;
    logic        pbit;
    logic [1:0]  stops;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 6; n++) begin
        d = 9'($urandom) & 9'((1 << nd[k]) - 1);
        if ($urandom_range(0, 5) == 0) d = '0;
        pbit  = ($countones(d) % 2 == 1) ^ ($urandom_range(0, 3) == 0);
        stops = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
        m = model_frame(k, d, pm[k], pbit, ns[k], stops);
        send_frame(k, d, nd[k], pm[k], pbit, ns[k], stops, t0);
        idle_bits(k, $urandom_range(2, 4));
        wait_rec(got, r, 200);
        total++;
        if (!got || r.k != k || r.data !== m.data || r.perr !== m.perr || r.ferr !== m.ferr ||
            r.brk !== m.brk || r.ovr !== 1'b0) begin
          $display("FAIL random_%0d_%0d: got v=%0d dut=%0d %h p%b f%b b%b o%b want %h p%b f%b b%b",
                   k, n, got, r.k, r.data, r.perr, r.ferr, r.brk, r.ovr, m.data, m.perr, m.ferr,
                   m.brk);
          bad++;
        end
        total++;
        if (q.size() != 0) begin
          $display("FAIL random_extra_%0d_%0d: got %0d extra words want 0", k, n, q.size());
          bad++;
          q.delete();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_break();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name:
uart_rx_param

Overview:
- Parametrised UART receiver; next generation of the fixed 8/N/1 receiver.
- Configurable data width, parity and stop bits.
- Adds input synchroniser, 3-sample majority vote, false-start rejection, parity/framing/break detection, and a valid/ready output holding register with overrun flag.
- Sits between the pad/IO mux and SoC peripheral FIFOs or CSR logic.

Parameters:
- CLK_FREQ, 250000, system clock in Hz.
- BAUD, 9600, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD must be >= 4 (elaboration-time assertion).
- DATA_BITS, 8, data width, legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, legal values 1 or 2.
- SYNC_STAGES, 2, synchroniser depth, >= 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_in  in  1  asynchronous serial line, idle high.
- o_data  out  DATA_BITS  received word, LSB first on the line.
- o_valid  out  1  word held and available.
- i_ready  in  1  consumer accepts; transfer when o_valid && i_ready.
- o_parity_err  out  1  parity mismatch for the held word (0 when PARITY = 0).
- o_frame_err  out  1  a stop bit was sampled low.
- o_break  out  1  break condition: data, parity and stop all low.
- o_overrun  out  1  at least one frame lost while the word was held.

Behaviour:
- Single clock i_clk. Reset is synchronous, active-high, on i_rst.
- Reset values:
  - synchroniser flops = 1; state = IDLE; counters = 0.
  - o_data = 0; o_valid, o_parity_err, o_frame_err, o_break, o_overrun = 0.
  - Reset mid-frame abandons the frame; no o_valid results from it.
- Synchroniser: i_in passes through SYNC_STAGES flops. All logic below uses the synchronised value s.
- Bit timing:
  - Cycle counter runs 0..CLKS_PER_BIT-1 within each bit; H = CLKS_PER_BIT/2.
  - s is sampled at counts H-1, H and H+1; the bit value is the majority of the three.
  - The decision is taken at count H+1.
- IDLE:
  - s == 0 -> START, counter = 0. That cycle is count 0 of the start bit.
- START:
  - At the decision, majority 1 -> IDLE (false start, no output, no flags).
  - Majority 0 -> DATA.
- DATA:
  - DATA_BITS bits, shifted in LSB first.
  - Then PARITY if PARITY != 0, else STOP.
- PARITY:
  - Error when XOR(data, parity bit) is 0 for odd, or 1 for even.
- STOP:
  - Majority 0 on any stop bit sets the frame error.
  - The frame completes on the decision cycle of the last stop bit, not at the end of the bit (early resync).
  - Go to IDLE, or to BREAK_WAIT if break is detected.
- Break:
  - Condition: data == 0, parity bit 0 (if enabled), first stop bit 0.
  - Set the break and frame error flags.
  - BREAK_WAIT holds until s == 1, then returns to IDLE. Only one o_valid is produced per break.
- Output register:
  - On the cycle after frame completion, o_valid = 1 with data and all flags.
  - Held stable until handshake.
  - Handshake with no new frame completing: o_valid = 0 next cycle; error flags cleared.
  - Completion in the same cycle as a handshake: the new frame loads, no overrun.
  - Completion while o_valid && !i_ready: the new frame is discarded; o_overrun = 1, sticky until the held word is accepted.
- Errored frames are still delivered, with their flags set.
- Latency:
  - Line edge to FSM: SYNC_STAGES cycles.
  - Last stop decision to o_valid: 1 cycle.

Decomposition:
- Package uart_pkg:
  - parity_t enum (NONE, ODD, EVEN);
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT);
  - function calc_parity(data, mode).
- Sub-module uart_rx_sampler: synchroniser, bit-cycle counter and majority vote. Outputs:
  - sample_valid, a 1-cycle pulse at the decision;
  - bit_value;
  - bit_end.

Test Plan:
- Setup: CLK_FREQ = 16000000, BAUD = 1000000 (16 clocks/bit), defaults otherwise.
  1. Send 0xA5 as 8N1 -> one o_valid with o_data = 0xA5, all flags 0. o_valid rises 1 cycle after the stop-bit decision (count 9).
  2. PARITY = 2, send 0x07 with parity bit 1 -> o_parity_err = 0. Same word with parity bit 0 -> o_parity_err = 1, o_data = 0x07.
  3. Drive i_in low for 4 clocks only -> FSM returns to IDLE, no o_valid. A following 0x3C frame is received correctly.
  4. Send 0x55 with stop bit low -> o_frame_err = 1, o_break = 0. Then line low for 20 bit times -> one o_valid with o_data = 0x00, o_break = 1, o_frame_err = 1. No further o_valid until the line returns high; the next 0x81 frame is received.
  5. i_ready = 0, send 0x11 then 0x22 -> o_data stays 0x11, o_overrun = 1. Raise i_ready -> handshake, then o_valid = 0 and o_overrun = 0.
  6. Assert i_rst during data bit 3 of a frame -> no o_valid, all outputs 0. The next 0x3C frame is received; also check STOP_BITS = 2, DATA_BITS = 7 with 0x7F.
